mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words of backing storage; power of two.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before a non-faulting access completes; range 0..15.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  request offered by initiator.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_is_write  input  1  1=write, 0=read.
REQ-009 req_is_unsigned  input  1  read byte/half is zero-extended (1) or sign-extended (0).
REQ-010 req_op  input  2  access size: 00=byte, 01=half-word, 10=word, 11=invalid.
REQ-011 req_addr  input  32  byte address.
REQ-012 req_wdata  input  32  write data, right-justified for byte/half.
REQ-013 resp_valid  output  1  response available.
REQ-014 resp_ready  input  1  initiator consumes response.
REQ-015 resp_rdata  output  32  read result, extended to 32 bits; 0 for writes and faults.
REQ-016 resp_fault  output  1  request was invalid, misaligned or out of range; qualified by resp_valid.

Function
REQ-017 States: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 Request accepted on the cycle req_valid & req_ready; all req_* fields captured into registers that cycle and ignored thereafter until IDLE.
REQ-019 Fault on accept = (op==11) | (op==01 & addr[0]) | (op==10 & addr[1:0]!=0) | ((addr - BASE_ADDR) >= DEPTH_WORDS*4), unsigned 32-bit subtraction.
REQ-020 Faulting request: IDLE -> RESP directly; resp_valid=1, resp_fault=1, resp_rdata=0 in the cycle after accept; storage unmodified.
REQ-021 Non-faulting request with WAIT_CYCLES>0: IDLE -> WAIT; counter loaded with WAIT_CYCLES-1, decremented per cycle; WAIT -> RESP when counter is 0.
REQ-022 Non-faulting request with WAIT_CYCLES=0: IDLE -> RESP directly.
REQ-023 Latency: accept in cycle N gives resp_valid first high in cycle N+1+WAIT_CYCLES (N+1 for faults).
REQ-024 Storage read/write SHALL occur on the transition into RESP only; word index = (addr - BASE_ADDR)[log2(DEPTH_WORDS*4)-1:2].
REQ-025 Write lanes: byte writes wdata[7:0] to lane addr[1:0]; half writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}; word writes all four lanes; other lanes unchanged.
REQ-026 Read extraction: byte from bits [8*addr[1:0]+7 -: 8], half from bits [16*addr[1]+15 -: 16], word whole; extended per captured req_is_unsigned.
REQ-027 In RESP, resp_valid, resp_rdata and resp_fault SHALL hold stable until resp_ready=1; RESP -> IDLE on resp_valid & resp_ready.
REQ-028 No back-to-back overlap: a new request is accepted no earlier than the cycle after the response handshake.
REQ-029 Storage contents are not initialised; reads of never-written locations are undefined.

Reset
REQ-030 On reset: state=IDLE, req_ready=1 in the following cycle, resp_valid=0, resp_fault=0, resp_rdata=0, wait counter=0.
REQ-031 Reset in WAIT SHALL abandon the pending access with no storage write; reset in RESP drops the response.
REQ-032 Reset takes priority over a simultaneous accept or response handshake.

Structure
REQ-033 Shared package holds the op-size enum (BYTE, HALF, WORD, INVALID) and state enum; initiator and responder both import it.
REQ-034 One sub-module mem_sram: synchronous single-port DEPTH_WORDS x 32 array with 4-bit byte-enable write and combinational read of the addressed word.
REQ-035 Lane steering, extension and fault decode live in mem_responder.

Verification (WAIT_CYCLES=2, BASE_ADDR=0, DEPTH_WORDS=1024)
REQ-036 Word write 0x100=0xDEADBEEF accepted cycle N -> resp_valid at N+3, fault 0; word read 0x100 -> 0xDEADBEEF.
REQ-037 After REQ-036: byte unsigned 0x103 -> 0x000000DE; byte signed 0x100 -> 0xFFFFFFEF; half signed 0x102 -> 0xFFFFDEAD; half unsigned 0x100 -> 0x0000BEEF.
REQ-038 Half write 0x101, op=11 at 0x100, word read 0x1000 -> each resp_fault=1 at N+1, rdata 0; word read 0x100 still 0xDEADBEEF.
REQ-039 Byte write 0x102=0x55 -> word read 0x100 returns 0xDE55BEEF.
REQ-040 resp_ready held 0 for 5 cycles in RESP -> resp_valid/rdata stable, req_ready 0, second req_valid not accepted until cycle after handshake.
REQ-041 0x200 holds 0; word write 0x12345678 to 0x200, reset asserted in first WAIT cycle -> next cycle resp_valid 0, req_ready 1; read 0x200 returns 0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types for the memory request/response protocol: access sizes and
// the responder's state encoding, imported by both initiator and responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    INVALID = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/mem_responder_sram.sv
// Single-port word store with per-byte write enables and a combinational
// read of the addressed word; one narrow array per byte lane.
module mem_sram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_lane [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (i_we && i_be[gi]) begin
          r_lane[i_addr] <= i_wdata[8*gi +: 8];
        end
      end

      assign o_rdata[8*gi +: 8] = r_lane[i_addr];
    end
  endgenerate

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one sized access at a time, decodes faults,
// inserts wait states, then holds the response until the initiator takes it.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_write,
  input  logic        req_is_unsigned,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic        r_is_write;
  logic        r_is_unsigned;
  op_e         r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_fault;
  logic [31:0] r_resp_rdata;

  logic        w_in_idle;
  logic        w_accept;
  op_e         w_op;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_is_write;
  logic        w_is_unsigned;
  logic [31:0] w_offset;
  logic        w_fault;
  logic        w_enter_resp;
  logic        w_we;
  logic [3:0]  w_be;
  logic [31:0] w_sram_wdata;
  logic [31:0] w_rd_word;
  logic [15:0] w_shift;
  logic [31:0] w_rd_ext;
  logic [31:0] w_resp_data;

  // The access fires on the edge entering RESP; from IDLE (zero wait states)
  // that is the accept edge, so the live request fields are used instead of
  // the captured ones.
  assign w_in_idle     = (r_state == IDLE);
  assign w_accept      = req_valid & r_req_ready;
  assign w_op          = w_in_idle ? op_e'(req_op) : r_op;
  assign w_addr        = w_in_idle ? req_addr : r_addr;
  assign w_wdata       = w_in_idle ? req_wdata : r_wdata;
  assign w_is_write    = w_in_idle ? req_is_write : r_is_write;
  assign w_is_unsigned = w_in_idle ? req_is_unsigned : r_is_unsigned;

  assign w_offset = w_addr - BASE_ADDR;
  assign w_fault  = (w_op == INVALID)
                  | ((w_op == HALF) & w_addr[0])
                  | ((w_op == WORD) & (w_addr[1:0] != 2'b00))
                  | (w_offset >= SPAN);

  assign w_enter_resp = w_in_idle ? (w_accept & ~w_fault & (WAIT_CYCLES == 0))
                                  : ((r_state == WAIT) & (r_cnt == 4'd0));
  assign w_we = w_enter_resp & w_is_write & ~reset;

  always_comb begin
    w_be         = 4'b1111;
    w_sram_wdata = w_wdata;
    case (w_op)
      BYTE: begin
        w_be         = 4'b0001 << w_addr[1:0];
        w_sram_wdata = {4{w_wdata[7:0]}};
      end
      HALF: begin
        w_be         = w_addr[1] ? 4'b1100 : 4'b0011;
        w_sram_wdata = {2{w_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  mem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_addr  (w_offset[AW+1:2]),
    .i_wdata (w_sram_wdata),
    .o_rdata (w_rd_word)
  );

  // Aligned halves have addr[0]=0, so one byte-granular shift serves both sizes.
  assign w_shift = 16'(w_rd_word >> {w_addr[1:0], 3'b000});

  always_comb begin
    case (w_op)
      BYTE:    w_rd_ext = {{24{~w_is_unsigned & w_shift[7]}},  w_shift[7:0]};
      HALF:    w_rd_ext = {{16{~w_is_unsigned & w_shift[15]}}, w_shift};
      default: w_rd_ext = w_rd_word;
    endcase
  end

  assign w_resp_data = w_is_write ? 32'd0 : w_rd_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= 4'd0;
      r_is_write    <= 1'b0;
      r_is_unsigned <= 1'b0;
      r_op          <= BYTE;
      r_addr        <= 32'd0;
      r_wdata       <= 32'd0;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_fault  <= 1'b0;
      r_resp_rdata  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_is_write    <= req_is_write;
            r_is_unsigned <= req_is_unsigned;
            r_op          <= op_e'(req_op);
            r_addr        <= req_addr;
            r_wdata       <= req_wdata;
            r_req_ready   <= 1'b0;
            if (w_fault) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else if (WAIT_CYCLES == 0) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b0;
              r_resp_rdata <= w_resp_data;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= w_resp_data;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= 32'd0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_fault = r_resp_fault;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: expected responses are queued when a
// request is driven and checked when the response appears.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int WAIT_CYCLES = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_write;
  logic        req_is_unsigned;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sb[$];

  mem_responder #(
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (WAIT_CYCLES),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_write    (req_is_write),
    .req_is_unsigned (req_is_unsigned),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_fault      (resp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction; hold>0 keeps resp_ready low that many cycles while
  // offering a further request that must not be taken.
  task automatic do_req(input string tag, input logic wr, input logic uns,
                        input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_f, input int hold);
    exp_t e;
    int   n;
    int   lat;
    e.rdata = exp_rd;
    e.fault = exp_f;
    e.lat   = exp_f ? 1 : 1 + WAIT_CYCLES;
    sb.push_back(e);
    req_is_write    = wr;
    req_is_unsigned = uns;
    req_op          = op;
    req_addr        = addr;
    req_wdata       = wdata;
    req_valid       = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
    chk({tag, "_rdata"}, resp_rdata, e.rdata);
    chk({tag, "_fault"}, 32'(resp_fault), 32'(e.fault));
    if (hold > 0) begin
      req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_hold_rdata"}, resp_rdata, e.rdata);
        chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, "_resp_done"}, 32'(resp_valid), 32'd0);
    if (hold > 0) chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset           = 1'b1;
    req_valid       = 1'b0;
    req_is_write    = 1'b0;
    req_is_unsigned = 1'b0;
    req_op          = 2'b00;
    req_addr        = 32'd0;
    req_wdata       = 32'd0;
    resp_ready      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);

    do_req("wr_word",   1'b1, 1'b0, WORD, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    do_req("rd_word",   1'b0, 1'b0, WORD, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    do_req("rd_bu_103", 1'b0, 1'b1, BYTE, 32'h103, 32'h0, 32'h000000DE, 1'b0, 0);
    do_req("rd_bs_100", 1'b0, 1'b0, BYTE, 32'h100, 32'h0, 32'hFFFFFFEF, 1'b0, 0);
    do_req("rd_hs_102", 1'b0, 1'b0, HALF, 32'h102, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
    do_req("rd_hu_100", 1'b0, 1'b1, HALF, 32'h100, 32'h0, 32'h0000BEEF, 1'b0, 0);

    do_req("flt_half",  1'b1, 1'b0, HALF,    32'h101,  32'h1234, 32'h0, 1'b1, 0);
    do_req("flt_op",    1'b0, 1'b0, INVALID, 32'h100,  32'h0,    32'h0, 1'b1, 0);
    do_req("flt_range", 1'b0, 1'b0, WORD,    32'h1000, 32'h0,    32'h0, 1'b1, 0);
    do_req("rd_intact", 1'b0, 1'b0, WORD,    32'h100,  32'h0, 32'hDEADBEEF, 1'b0, 0);

    do_req("wr_byte",   1'b1, 1'b0, BYTE, 32'h102, 32'h55, 32'h0, 1'b0, 0);
    do_req("rd_merge",  1'b0, 1'b0, WORD, 32'h100, 32'h0, 32'hDE55BEEF, 1'b0, 5);
    do_req("rd_next",   1'b0, 1'b0, WORD, 32'h100, 32'h0, 32'hDE55BEEF, 1'b0, 0);

    // Reset landing in the first wait cycle must discard the pending write.
    do_req("wr_zero",   1'b1, 1'b0, WORD, 32'h200, 32'h0, 32'h0, 1'b0, 0);
    req_is_write = 1'b1;
    req_op       = WORD;
    req_addr     = 32'h200;
    req_wdata    = 32'h12345678;
    req_valid    = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstw_req_ready", 32'(req_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("rstw_no_resp", 32'(resp_valid), 32'd0);
    do_req("rd_after_rst", 1'b0, 1'b0, WORD, 32'h200, 32'h0, 32'h0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
